// File: rtl/switch_debounce8_if.sv
// Switch-debouncer signal bundle: raw levels in, debounced levels and update pulses out.
// rise/fall exist only when DEBOUNCE_EDGE_EN is defined.
interface switch_debounce8_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             changed;
`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output sw_in,
        input  sw_out,
        input  changed,
        input  rise,
        input  fall
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output changed,
        output rise,
        output fall
    );
`else
    modport master (
        output sw_in,
        input  sw_out,
        input  changed
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output changed
    );
`endif
endinterface

// File: rtl/switch_debounce8.sv
// Two-flop synchroniser plus per-bit stability counter for 8 board switches feeding eightand.
// Optional per-bit rise/fall pulses are built when DEBOUNCE_EDGE_EN is defined.
module switch_debounce8 #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    switch_debounce8_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            sw_out_q;
    logic [WIDTH-1:0]            sw_out_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            update;
    logic                        changed_q;

    // A bit flips only after STABLE_CYCLES consecutive disagreeing synced samples.
    always_comb begin
        update = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                update[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        sw_out_d = sw_out_q ^ update;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            sw_out_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= bus.sw_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            sw_out_q  <= sw_out_d;
            changed_q <= |update;
        end
    end

    assign bus.sw_out  = sw_out_q;
    assign bus.changed = changed_q;

`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= update & sync2_q;
            fall_q <= update & ~sync2_q;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cnt_chk
        cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q[gi] <= CntMax);
    end
`endif
endmodule

// File: tb/tb_switch_debounce8.sv
// Self-checking bench for switch_debounce8: directed scenarios plus randomized stimulus
// compared against a sliding-window reference model.
module tb_switch_debounce8;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    switch_debounce8_if #(.WIDTH(8)) bus ();

    switch_debounce8 #(
        .WIDTH        (8),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: sw_in samples per edge, newest at index 0; a bit flips when every synced sample
    // (two edges old) in the last S edges disagrees with the current output.
    logic [7:0] smp [0:S+1];
    logic [7:0] m_out, m_rise, m_fall;
    logic       m_changed;

    task automatic model_reset();
        for (int j = 0; j <= S + 1; j++) smp[j] = 8'h00;
        m_out     = 8'h00;
        m_rise    = 8'h00;
        m_fall    = 8'h00;
        m_changed = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] v);
        logic [7:0] upd;
        if (rst) begin
            model_reset();
        end else begin
            for (int j = S + 1; j > 0; j--) smp[j] = smp[j-1];
            smp[0] = v;
            upd = 8'hFF;
            for (int j = 2; j <= S + 1; j++) upd &= smp[j] ^ m_out;
            m_changed = |upd;
            m_rise    = upd & ~m_out;
            m_fall    = upd & m_out;
            m_out     = m_out ^ upd;
        end
    endtask

    // Drive at negedge, advance model on posedge, return at next negedge for sampling.
    task automatic step(input logic [7:0] v);
        bus.sw_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(8'hFF);
            n_total++;
            if (bus.sw_out !== 8'h00)
                $display("FAIL reset_sw_out: got %h want 00", bus.sw_out);
            else n_pass++;
            n_total++;
            if (bus.changed !== 1'b0)
                $display("FAIL reset_changed: got %b want 0", bus.changed);
            else n_pass++;
            n_total++;
            if ((&bus.sw_out) !== 1'b0)
                $display("FAIL reset_and_out: got %b want 0", &bus.sw_out);
            else n_pass++;
        end
    endtask

    task automatic test_single_change();
        int pulses = 0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(8'h00);
        for (int k = 1; k <= 9; k++) begin
            step(8'h12);
            if (bus.changed === 1'b1) pulses++;
            n_total++;
            if (bus.sw_out !== m_out)
                $display("FAIL single_model_sw_out e%0d: got %h want %h", k, bus.sw_out, m_out);
            else n_pass++;
            if (k == 5) begin
                n_total++;
                if (bus.sw_out !== 8'h00)
                    $display("FAIL single_e5_sw_out: got %h want 00", bus.sw_out);
                else n_pass++;
            end
            if (k == 6) begin
                n_total++;
                if (bus.sw_out !== 8'h12 || bus.changed !== 1'b1)
                    $display("FAIL single_e6: got sw_out=%h changed=%b want 12/1",
                             bus.sw_out, bus.changed);
                else n_pass++;
`ifdef DEBOUNCE_EDGE_EN
                n_total++;
                if (bus.rise !== 8'h12 || bus.fall !== 8'h00)
                    $display("FAIL single_e6_edges: got rise=%h fall=%h want 12/00",
                             bus.rise, bus.fall);
                else n_pass++;
`endif
            end
        end
        n_total++;
        if (pulses !== 1) $display("FAIL single_pulses: got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int k = 0; k < 11; k++) begin
            step(k < 3 ? 8'h13 : 8'h12);
            if (bus.sw_out !== 8'h12 || bus.changed !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL glitch: got %0d disturbed cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (m_out !== bus.sw_out)
            $display("FAIL glitch_model: got %h want %h", bus.sw_out, m_out);
        else n_pass++;
    endtask

    task automatic test_toggle();
        int pulses = 0;
        int odd    = 0;
        for (int k = 0; k < 20; k++) begin
            step((k < 10 && k % 2 == 0) ? 8'h00 : 8'hFF);
            if (bus.changed === 1'b1) pulses++;
            if (bus.sw_out !== 8'h12 && bus.sw_out !== 8'hFF) odd++;
            n_total++;
            if (bus.sw_out !== m_out || bus.changed !== m_changed)
                $display("FAIL toggle_model k%0d: got %h/%b want %h/%b",
                         k, bus.sw_out, bus.changed, m_out, m_changed);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 1 || odd !== 0)
            $display("FAIL toggle_updates: got pulses=%0d odd=%0d want 1/0", pulses, odd);
        else n_pass++;
        n_total++;
        if (bus.sw_out !== 8'hFF || (&bus.sw_out) !== 1'b1)
            $display("FAIL toggle_final: got %h want ff, and_out=1", bus.sw_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) step(8'h7F);
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (bus.sw_out !== 8'h00 || bus.changed !== 1'b0)
            $display("FAIL midrst_immediate: got %h/%b want 00/0", bus.sw_out, bus.changed);
        else n_pass++;
        @(negedge clk);
        step(8'h7F);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(8'h7F);
            if (k == 5) begin
                n_total++;
                if (bus.sw_out !== 8'h00)
                    $display("FAIL midrst_e5: got %h want 00", bus.sw_out);
                else n_pass++;
            end
            if (k == 6) begin
                n_total++;
                if (bus.sw_out !== 8'h7F || (&bus.sw_out) !== 1'b0)
                    $display("FAIL midrst_e6: got %h want 7f, and_out=0", bus.sw_out);
                else n_pass++;
            end
            n_total++;
            if (bus.sw_out !== m_out)
                $display("FAIL midrst_model e%0d: got %h want %h", k, bus.sw_out, m_out);
            else n_pass++;
        end
    endtask

    task automatic test_fall();
        for (int k = 0; k < 8; k++) step(8'hFF);
        for (int k = 1; k <= 7; k++) begin
            step(8'h00);
            n_total++;
            if (bus.changed !== (k == 6) || bus.sw_out !== (k >= 6 ? 8'h00 : 8'hFF))
                $display("FAIL fall_e%0d: got %h/%b", k, bus.sw_out, bus.changed);
            else n_pass++;
`ifdef DEBOUNCE_EDGE_EN
            n_total++;
            if (bus.fall !== (k == 6 ? 8'hFF : 8'h00) || bus.rise !== 8'h00)
                $display("FAIL fall_edges_e%0d: got rise=%h fall=%h", k, bus.rise, bus.fall);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0] v = 8'h00;
        int bad = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) v = v ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                model_reset();
                step(v);
                rst = 1'b0;
            end
            step(v);
            if (bus.sw_out !== m_out || bus.changed !== m_changed) bad++;
`ifdef DEBOUNCE_EDGE_EN
            if (bus.rise !== m_rise || bus.fall !== m_fall) bad++;
`endif
            if (bad == 1 && (bus.sw_out !== m_out || bus.changed !== m_changed))
                $display("FAIL random_first k%0d: got %h/%b want %h/%b",
                         k, bus.sw_out, bus.changed, m_out, m_changed);
        end
        n_total++;
        if (bad !== 0) $display("FAIL random: got %0d mismatching cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        bus.sw_in = 8'h00;
        model_reset();
        test_reset();
        test_single_change();
        test_glitch();
        test_toggle();
        test_reset_mid();
        test_fall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
